// File: rtl/layered_rgb_mux.sv
// Two-stage pixel compositor: prioritised sprite layers with colour key, blink and enable,
// plus an overriding overlay, a background fallback and per-frame layer-overlap flags.
module layered_rgb_mux #(
  parameter int                 NUM_LAYERS   = 16,
  parameter int                 RGB_W        = 8,
  parameter logic [RGB_W-1:0]   TRANSPARENT  = 8'hDB,
  parameter int                 BLINK_FRAMES = 30
) (
  input  logic                                 clk,
  input  logic                                 resetN,
  input  logic                                 startOfFrame,
  input  logic [NUM_LAYERS-1:0]                layerDR,
  input  logic [NUM_LAYERS*RGB_W-1:0]          layerRGB,
  input  logic [NUM_LAYERS-1:0]                layerEnable,
  input  logic [NUM_LAYERS-1:0]                keyEnable,
  input  logic [NUM_LAYERS-1:0]                blinkEnable,
  input  logic                                 overlayDR,
  input  logic [RGB_W-1:0]                     overlayRGB,
  input  logic [RGB_W-1:0]                     backGroundRGB,
  output logic [RGB_W-1:0]                     RGBOut,
  output logic [$clog2(NUM_LAYERS+2)-1:0]      winnerIdx,
  output logic                                 winnerValid,
  output logic [NUM_LAYERS-1:0]                overlapMaskPrev
);

  localparam int IDX_W = $clog2(NUM_LAYERS+2);
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES-1);

  logic [CNT_W-1:0]            frame_cnt_reg;
  logic                        blink_phase_reg;
  logic [NUM_LAYERS-1:0]       eff;
  logic [NUM_LAYERS-1:0]       eff1_reg;
  logic [NUM_LAYERS*RGB_W-1:0] rgb1_reg;
  logic                        ovl_dr1_reg;
  logic [RGB_W-1:0]            ovl_rgb1_reg;
  logic [RGB_W-1:0]            bg1_reg;
  logic [NUM_LAYERS-1:0]       accum_reg;
  logic [NUM_LAYERS-1:0]       contrib;
  logic                        multi_hit;
  logic [RGB_W-1:0]            win_rgb_next;
  logic [IDX_W-1:0]            win_idx_next;
  logic                        win_valid_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LAYERS; gi++) begin : g_eff
      assign eff[gi] = layerDR[gi] & layerEnable[gi]
                     & ~(keyEnable[gi] & (layerRGB[gi*RGB_W +: RGB_W] == TRANSPARENT))
                     & ~(blinkEnable[gi] & blink_phase_reg);
    end
  endgenerate

  // Clearing the lowest set bit leaves something only when two or more layers hit.
  assign multi_hit = |(eff1_reg & (eff1_reg - NUM_LAYERS'(1)));
  assign contrib   = multi_hit ? eff1_reg : '0;

  // Walk from the lowest priority up so the lowest index is written last and wins.
  always_comb begin
    win_rgb_next   = bg1_reg;
    win_idx_next   = IDX_W'(NUM_LAYERS);
    win_valid_next = 1'b0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (eff1_reg[i]) begin
        win_rgb_next   = rgb1_reg[i*RGB_W +: RGB_W];
        win_idx_next   = IDX_W'(i);
        win_valid_next = 1'b1;
      end
    end
    if (ovl_dr1_reg) begin
      win_rgb_next   = ovl_rgb1_reg;
      win_idx_next   = IDX_W'(NUM_LAYERS + 1);
      win_valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      frame_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
    end else if (startOfFrame) begin
      if (frame_cnt_reg == CNT_LAST) begin
        frame_cnt_reg   <= '0;
        blink_phase_reg <= ~blink_phase_reg;
      end else begin
        frame_cnt_reg   <= frame_cnt_reg + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      eff1_reg     <= '0;
      rgb1_reg     <= '0;
      ovl_dr1_reg  <= 1'b0;
      ovl_rgb1_reg <= '0;
      bg1_reg      <= '0;
      RGBOut       <= '0;
      winnerIdx    <= '0;
      winnerValid  <= 1'b0;
    end else begin
      eff1_reg     <= eff;
      rgb1_reg     <= layerRGB;
      ovl_dr1_reg  <= overlayDR;
      ovl_rgb1_reg <= overlayRGB;
      bg1_reg      <= backGroundRGB;
      RGBOut       <= win_rgb_next;
      winnerIdx    <= win_idx_next;
      winnerValid  <= win_valid_next;
    end
  end

  // The startOfFrame cycle's own contribution opens the new frame's accumulation.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      accum_reg       <= '0;
      overlapMaskPrev <= '0;
    end else if (startOfFrame) begin
      overlapMaskPrev <= accum_reg;
      accum_reg       <= contrib;
    end else begin
      accum_reg       <= accum_reg | contrib;
    end
  end

endmodule

// File: doc/layered_rgb_mux.md
# layered_rgb_mux

Parametrised, pipelined successor to the pinball VGA object multiplexer. It composites NUM_LAYERS sprite/object layers plus a full-screen overlay and the background into one registered pixel colour. Each layer has an index-ordered priority, optional colour-key transparency, a frame-synchronous blink and an enable gate. The block also reports per-frame layer overlap flags for game logic such as collision and teleporter hits. It sits between the object drawers and the VGA output stage.

## Interface
Parameters:
- NUM_LAYERS, 16: number of priority layers; layer 0 has the highest priority.
- RGB_W, 8: pixel colour width (3-3-2 RGB at 8).
- TRANSPARENT, 8'hDB: colour-key value, RGB_W bits wide.
- BLINK_FRAMES, 30: number of frames per blink half-period, ≥1.

Ports:
- clk  in  1  pixel clock.
- resetN  in  1  reset; asynchronous, active-low.
- startOfFrame  in  1  one-cycle pulse per frame, asserted during blanking.
- layerDR  in  NUM_LAYERS  per-layer drawing request.
- layerRGB  in  NUM_LAYERS*RGB_W  packed colours; layer i occupies bits [i*RGB_W +: RGB_W].
- layerEnable  in  NUM_LAYERS  static layer gate.
- keyEnable  in  NUM_LAYERS  enables the TRANSPARENT colour key per layer.
- blinkEnable  in  NUM_LAYERS  layer takes part in blinking.
- overlayDR  in  1  overlay (game-over screen) request; wins over everything.
- overlayRGB  in  RGB_W  overlay colour; never colour-keyed.
- backGroundRGB  in  RGB_W  colour used when nothing is drawn.
- RGBOut  out  RGB_W  composited pixel.
- winnerIdx  out  $clog2(NUM_LAYERS+2)  winning source: layer index i, NUM_LAYERS for background, NUM_LAYERS+1 for overlay.
- winnerValid  out  1  high when a layer or the overlay won; low for background.
- overlapMaskPrev  out  NUM_LAYERS  overlap flags from the previous completed frame.

## Operation
- Effective request per layer: eff[i] = layerDR[i] & layerEnable[i] & !(keyEnable[i] & layerRGB[i]==TRANSPARENT) & !(blinkEnable[i] & blinkPhase).
- Stage 1 registers eff, all layer colours, overlayDR, overlayRGB and backGroundRGB.
- Stage 2 makes a priority choice from the stage-1 registers, highest first:
  - overlay;
  - then the lowest i with eff[i] set;
  - then background.
  It registers RGBOut, winnerIdx and winnerValid.
- Blink state:
  - frameCnt counts 0..BLINK_FRAMES-1 and advances on each startOfFrame.
  - A startOfFrame arriving while frameCnt==BLINK_FRAMES-1 sets frameCnt to 0 and toggles blinkPhase.
  - blinkPhase=1 hides the blinking layers.
  - With BLINK_FRAMES=1, blinkPhase toggles on every frame.
- Overlap accumulation:
  - contrib[i] = eff1[i] & (popcount(eff1) ≥ 2), where eff1 is the stage-1 registered mask.
  - The overlay and background do not contribute.
  - accum |= contrib on every cycle.
- Frame boundary: on a cycle with startOfFrame high:
  - overlapMaskPrev <= accum;
  - accum <= contrib of that same cycle, so that cycle's pixel belongs to the new frame.
- The overlay does not suppress overlap detection; underlying layers still accumulate.

## Timing
- Latency is 2 clk from inputs to RGBOut, winnerIdx and winnerValid. Object drawers must delay their pixel coordinates by 2 relative to sync. Sync is not delayed inside this block.
- Throughput is one pixel per clk with no stalls.
- Blink: blinkPhase changes on the clk edge that samples startOfFrame. The first affected pixel appears at RGBOut 2 clk later.
- overlapMaskPrev updates on the edge that samples startOfFrame and holds for the whole next frame.
- Reset, asynchronous:
  - outputs: RGBOut=0, winnerIdx=0, winnerValid=0, overlapMaskPrev=0;
  - internal state: stage-1 registers=0, accum=0, frameCnt=0, blinkPhase=0 (visible).
- Reset mid-frame discards the partial accum. The first snapshot after reset covers only the post-reset part of the frame.
- The layer inputs are combinational to stage 1; no input flops are assumed upstream.

## Test plan
- **Reset:** assert resetN=0 mid-stream -> all outputs 0 immediately. After release with no DR and background 8'h25 -> RGBOut=8'h25, winnerIdx=NUM_LAYERS, winnerValid=0 on the 2nd edge.
- **Priority:**
  - Stimulus: layers 2 and 5 drawn with 8'h1C and 8'hE0.
  - Response 2 clk later: RGBOut=8'h1C, winnerIdx=2, winnerValid=1.
  - Then drop layer 2 -> RGBOut=8'hE0, winnerIdx=5.
- **Colour key:**
  - Stimulus: layer 2 RGB=8'hDB with keyEnable[2]=1, layer 5 RGB=8'hE0.
  - Response: RGBOut=8'hE0.
  - Then set keyEnable[2]=0 -> RGBOut=8'hDB, winnerIdx=2.
- **Overlay:** overlayDR=1 with 8'hFF while layers 0 and 3 are drawn -> RGBOut=8'hFF, winnerIdx=NUM_LAYERS+1.
- **Blink:**
  - Setup: BLINK_FRAMES=2, blinkEnable[0]=1, layer 0 drawn at 8'h03 over background 8'h25.
  - Frames 0-1 -> 8'h03.
  - After the 2nd startOfFrame -> 8'h25.
  - After the 4th startOfFrame -> 8'h03 again.
- **Overlap:**
  - Frame N: layers 1 and 3 overlap on one pixel, layer 4 is drawn alone.
  - Next startOfFrame -> overlapMaskPrev has bits 1 and 3 set only.
  - A following frame with no overlap -> overlapMaskPrev=0 at the next startOfFrame.
